// File: rtl/sram_bus_pkg.sv
// Shared types for the SRAM data-bus direction controller.
// Optional HOLD state is enabled with the BUS_HOLD_EN macro.
package sram_bus_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_TURN  = 3'd1,
    ST_WRITE = 3'd2,
    ST_HOLD  = 3'd3,
    ST_READ  = 3'd4
  } state_e;

  localparam logic DIR_READ  = 1'b0;
  localparam logic DIR_WRITE = 1'b1;

  function automatic int max_of4(input int a, input int b, input int c, input int d);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return m;
  endfunction

endpackage

// File: rtl/sram_bus_dir_ctrl_bidir_pad_bank.sv
// Tristate pad bank: drives dout onto pad when oe, otherwise releases it.
// din always reflects the resolved pad value.
module bidir_pad_bank #(
  parameter int W = 16
) (
  inout  wire  [W-1:0] pad,
  input  logic [W-1:0] dout,
  input  logic         oe,
  output logic [W-1:0] din
);

  assign pad = oe ? dout : {W{1'bz}};
  assign din = pad;

endmodule

// File: rtl/sram_bus_dir_ctrl.sv
// Sequenced bidirectional data-bus controller with turnaround dead cycles.
// Define BUS_HOLD_EN to extend each write drive by HOLD_CYCLES in a HOLD state.
import sram_bus_pkg::*;

// state | meaning
// IDLE  | waiting for a command, bus released, cmd_ready high
// TURN  | dead cycles after a direction change, bus released
// WRITE | driving registered write data onto bus_io
// HOLD  | extra drive of the same data (BUS_HOLD_EN builds only)
// READ  | memory output window, bus released, sampled on the final edge
module sram_bus_dir_ctrl #(
  parameter int DATA_WIDTH   = 16,
  parameter int TURNAROUND   = 1,
  parameter int WRITE_CYCLES = 2,
  parameter int READ_WAIT    = 2,
  parameter int HOLD_CYCLES  = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [DATA_WIDTH-1:0] cmd_wdata,
  output logic                  rd_valid,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  bus_oe,
  output logic                  bus_rd,
  output logic                  busy,
  inout  wire  [DATA_WIDTH-1:0] bus_io
);

  localparam int MAX_CYC = max_of4(TURNAROUND, WRITE_CYCLES, READ_WAIT, HOLD_CYCLES);
  localparam int CNT_W   = $clog2(MAX_CYC + 1);
  localparam bit HAS_TURN = (TURNAROUND > 0);

  // Counters load N-1 so the state lasts exactly N cycles.
  localparam logic [CNT_W-1:0] LD_TURN  = CNT_W'(HAS_TURN ? TURNAROUND - 1 : 0);
  localparam logic [CNT_W-1:0] LD_WRITE = CNT_W'(WRITE_CYCLES - 1);
  localparam logic [CNT_W-1:0] LD_READ  = CNT_W'(READ_WAIT - 1);
`ifdef BUS_HOLD_EN
  localparam logic [CNT_W-1:0] LD_HOLD  = CNT_W'(HOLD_CYCLES - 1);
`endif

  state_e                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  dir_q;
  logic                  wr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [DATA_WIDTH-1:0] bus_in;
  logic                  accept;
  logic                  sample;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      dir_q    <= DIR_READ;
      wr_q     <= DIR_READ;
      wdata_q  <= '0;
      rd_data  <= '0;
      rd_valid <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rd_valid <= sample;
      if (accept) begin
        wr_q    <= cmd_write;
        wdata_q <= cmd_wdata;
        dir_q   <= cmd_write;
      end
      if (sample) rd_data <= bus_in;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = (cnt_q != '0) ? cnt_q - 1'b1 : cnt_q;
    accept  = 1'b0;
    sample  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          accept = 1'b1;
          if (HAS_TURN && (cmd_write != dir_q)) begin
            state_d = ST_TURN;
            cnt_d   = LD_TURN;
          end else if (cmd_write == DIR_WRITE) begin
            state_d = ST_WRITE;
            cnt_d   = LD_WRITE;
          end else begin
            state_d = ST_READ;
            cnt_d   = LD_READ;
          end
        end
      end
      ST_TURN: begin
        if (cnt_q == '0) begin
          if (wr_q == DIR_WRITE) begin
            state_d = ST_WRITE;
            cnt_d   = LD_WRITE;
          end else begin
            state_d = ST_READ;
            cnt_d   = LD_READ;
          end
        end
      end
      ST_WRITE: begin
        if (cnt_q == '0) begin
`ifdef BUS_HOLD_EN
          state_d = ST_HOLD;
          cnt_d   = LD_HOLD;
`else
          state_d = ST_IDLE;
`endif
        end
      end
`ifdef BUS_HOLD_EN
      ST_HOLD: begin
        if (cnt_q == '0) state_d = ST_IDLE;
      end
`endif
      ST_READ: begin
        if (cnt_q == '0) begin
          sample  = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Decoded straight from state so an async reset releases the bus immediately.
  always_comb begin
    bus_oe    = (state_q == ST_WRITE) || (state_q == ST_HOLD);
    bus_rd    = (state_q == ST_READ);
    busy      = (state_q != ST_IDLE);
    cmd_ready = (state_q == ST_IDLE);
  end

  bidir_pad_bank #(.W(DATA_WIDTH)) u_pad (
    .pad  (bus_io),
    .dout (wdata_q),
    .oe   (bus_oe),
    .din  (bus_in)
  );

endmodule

// File: tb/tb_sram_bus_dir_ctrl.sv
// Self-checking bench for sram_bus_dir_ctrl: per-cycle expectations and read
// data are queued when a command is issued and popped as the DUT runs.
module tb_sram_bus_dir_ctrl;

  localparam int DW = 16;
  localparam int TA = 1;
  localparam int WC = 2;
  localparam int RW = 2;
  localparam int HC = 1;
`ifdef BUS_HOLD_EN
  localparam int DRV = WC + HC;
`else
  localparam int DRV = WC;
`endif
  localparam logic [DW-1:0] IDLE_PAT = 16'hF00F;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          cmd_valid = 1'b0;
  logic          cmd_write = 1'b0;
  logic [DW-1:0] cmd_wdata = '0;
  logic          cmd_ready, rd_valid, bus_oe, bus_rd, busy;
  logic [DW-1:0] rd_data;
  wire  [DW-1:0] bus_io;
  logic [DW-1:0] rd_pat = '0;

  // Memory model: returns rd_pat during the read window and a probe value
  // whenever the bus should be released, so stray drive shows up as a value error.
  assign bus_io = bus_oe ? {DW{1'bz}} : (bus_rd ? rd_pat : IDLE_PAT);

  sram_bus_dir_ctrl #(
    .DATA_WIDTH(DW), .TURNAROUND(TA), .WRITE_CYCLES(WC), .READ_WAIT(RW), .HOLD_CYCLES(HC)
  ) dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_write(cmd_write), .cmd_wdata(cmd_wdata), .rd_valid(rd_valid), .rd_data(rd_data),
    .bus_oe(bus_oe), .bus_rd(bus_rd), .busy(busy), .bus_io(bus_io)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic          oe;
    logic          rd;
    logic          busy;
    logic          rv;
    logic [DW-1:0] bus;
  } cyc_t;

  cyc_t          exp_q[$];
  logic [DW-1:0] rd_q[$];
  int            checks = 0;
  int            failures = 0;

  task automatic push_cyc(input logic oe, input logic rd, input logic bsy, input logic rv,
                          input logic [DW-1:0] bus);
    cyc_t e;
    e.oe = oe; e.rd = rd; e.busy = bsy; e.rv = rv; e.bus = bus;
    exp_q.push_back(e);
  endtask

  // Issue one command at the current negedge and check every cycle until the
  // controller is back in IDLE. noise keeps cmd_valid asserted while busy.
  task automatic run_cmd(input string name, input logic wr, input logic [DW-1:0] d,
                         input bit turn, input bit noise);
    cyc_t e;
    int   cyc;
    if (turn) for (int i = 0; i < TA; i++) push_cyc(1'b0, 1'b0, 1'b1, 1'b0, IDLE_PAT);
    if (wr) begin
      for (int i = 0; i < DRV; i++) push_cyc(1'b1, 1'b0, 1'b1, 1'b0, d);
      push_cyc(1'b0, 1'b0, 1'b0, 1'b0, IDLE_PAT);
    end else begin
      rd_pat = d;
      for (int i = 0; i < RW; i++) push_cyc(1'b0, 1'b1, 1'b1, 1'b0, d);
      push_cyc(1'b0, 1'b0, 1'b0, 1'b1, IDLE_PAT);
      rd_q.push_back(d);
    end

    checks++;
    if (cmd_ready !== 1'b1) begin
      failures++;
      $display("FAIL %s ready_before_issue got=%b want=1", name, cmd_ready);
    end
    cmd_valid = 1'b1;
    cmd_write = wr;
    cmd_wdata = wr ? d : 16'h0BAD;
    @(posedge clk);
    #1;
    cmd_valid = noise;
    cmd_write = ~wr;
    cmd_wdata = 16'hDEAD;

    cyc = 1;
    while (exp_q.size() > 0) begin
      @(negedge clk);
      e = exp_q.pop_front();
      checks++;
      if (bus_oe !== e.oe) begin
        failures++;
        $display("FAIL %s bus_oe T+%0d got=%b want=%b", name, cyc, bus_oe, e.oe);
      end
      checks++;
      if (bus_rd !== e.rd) begin
        failures++;
        $display("FAIL %s bus_rd T+%0d got=%b want=%b", name, cyc, bus_rd, e.rd);
      end
      checks++;
      if (busy !== e.busy || cmd_ready !== !e.busy) begin
        failures++;
        $display("FAIL %s busy/ready T+%0d got=%b/%b want=%b/%b", name, cyc, busy, cmd_ready,
                 e.busy, !e.busy);
      end
      checks++;
      if (bus_io !== e.bus) begin
        failures++;
        $display("FAIL %s bus_io T+%0d got=%h want=%h", name, cyc, bus_io, e.bus);
      end
      checks++;
      if (rd_valid !== e.rv) begin
        failures++;
        $display("FAIL %s rd_valid T+%0d got=%b want=%b", name, cyc, rd_valid, e.rv);
      end
      if (rd_valid === 1'b1) begin
        checks++;
        if (rd_q.size() == 0) begin
          failures++;
          $display("FAIL %s rd_data unexpected pulse got=%h want=none", name, rd_data);
        end else begin
          logic [DW-1:0] want;
          want = rd_q.pop_front();
          if (rd_data !== want) begin
            failures++;
            $display("FAIL %s rd_data got=%h want=%h", name, rd_data, want);
          end
        end
      end
      if (exp_q.size() <= 1) cmd_valid = 1'b0;
      cyc++;
    end
    checks++;
    if (rd_q.size() != 0) begin
      failures++;
      $display("FAIL %s rd_valid_missing got=%0d pending want=0", name, rd_q.size());
      rd_q.delete();
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    #1;
    checks++;
    if (bus_oe !== 1'b0 || bus_rd !== 1'b0 || busy !== 1'b0 || rd_valid !== 1'b0) begin
      failures++;
      $display("FAIL reset ctrl got=oe%b rd%b busy%b rv%b want=all 0", bus_oe, bus_rd, busy, rd_valid);
    end
    checks++;
    if (rd_data !== '0) begin
      failures++;
      $display("FAIL reset rd_data got=%h want=0000", rd_data);
    end
    checks++;
    if (bus_io !== IDLE_PAT) begin
      failures++;
      $display("FAIL reset bus_released got=%h want=%h", bus_io, IDLE_PAT);
    end
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if (cmd_ready !== 1'b1 || busy !== 1'b0) begin
      failures++;
      $display("FAIL reset release ready/busy got=%b/%b want=1/0", cmd_ready, busy);
    end
  endtask

  task automatic test_first_write();
    run_cmd("first_write", 1'b1, 16'hA5C3, 1'b1, 1'b0);
  endtask

  task automatic test_back_to_back_writes();
    run_cmd("b2b_write1", 1'b1, 16'h1111, 1'b0, 1'b0);
    run_cmd("b2b_write2", 1'b1, 16'h2222, 1'b0, 1'b0);
  endtask

  task automatic test_read_after_write();
    run_cmd("read_after_write", 1'b0, 16'h5A5A, 1'b1, 1'b1);
  endtask

  task automatic test_back_to_back_reads();
    run_cmd("b2b_read", 1'b0, 16'hC3C3, 1'b0, 1'b0);
  endtask

  task automatic test_reset_mid_write();
    checks++;
    if (cmd_ready !== 1'b1) begin
      failures++;
      $display("FAIL midrst ready_before_issue got=%b want=1", cmd_ready);
    end
    cmd_valid = 1'b1;
    cmd_write = 1'b1;
    cmd_wdata = 16'hABCD;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (bus_oe !== 1'b0) begin
      failures++;
      $display("FAIL midrst turn bus_oe got=%b want=0", bus_oe);
    end
    @(negedge clk);
    checks++;
    if (bus_oe !== 1'b1 || bus_io !== 16'hABCD) begin
      failures++;
      $display("FAIL midrst drive got=oe%b %h want=oe1 abcd", bus_oe, bus_io);
    end
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if (bus_oe !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL midrst async oe/busy got=%b/%b want=0/0", bus_oe, busy);
    end
    checks++;
    if (bus_io !== IDLE_PAT) begin
      failures++;
      $display("FAIL midrst async bus_io got=%h want=%h", bus_io, IDLE_PAT);
    end
    checks++;
    if (rd_data !== '0 || rd_valid !== 1'b0) begin
      failures++;
      $display("FAIL midrst rd_data/rd_valid got=%h/%b want=0000/0", rd_data, rd_valid);
    end
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    run_cmd("write_after_reset", 1'b1, 16'h0F0F, 1'b1, 1'b0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_first_write();
    test_back_to_back_writes();
    test_read_after_write();
    test_back_to_back_reads();
    test_reset_mid_write();
    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
